// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I subset decode stage with load-use stall and illegal-instruction lockout
module decode_stage #(
  parameter int XLEN          = 32,
  parameter int ILLEGAL_LIMIT = 4,
  parameter int CNT_W         = $clog2(ILLEGAL_LIMIT + 1),
  parameter int HAZARD_EN     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [3:0]       alu_ctrl,
  output logic             alu_src,
  output logic             reg_wen,
  output logic             mem_ren,
  output logic             mem_wen,
  output logic             branch,
  output logic             jump,
  output logic             illegal,
  output logic             locked,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic {RUN, LOCKED} state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ILLEGAL_LIMIT);

  state_t state;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic [XLEN-1:0] d_imm;
  logic [3:0] d_alu;
  logic d_src, d_wen, d_mren, d_mwen, d_br, d_jmp, d_ill;
  logic hazard, accept, f3_alu_ok;
  logic [3:0] f3_alu;
  logic [CNT_W-1:0] cnt_inc;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign cnt_inc = illegal_count + 1'b1;

  // Combinational decode of the incoming word; illegal encodings leave every field at zero
  always_comb begin
    d_rs1 = '0; d_rs2 = '0; d_rd = '0; d_imm = '0; d_alu = ALU_ADD;
    d_src = 1'b0; d_wen = 1'b0; d_mren = 1'b0; d_mwen = 1'b0;
    d_br = 1'b0; d_jmp = 1'b0; d_ill = 1'b0;
    f3_alu_ok = 1'b1;
    f3_alu = ALU_ADD;
    case (funct3)
      3'b000:  f3_alu = ALU_ADD;
      3'b111:  f3_alu = 4'b0010;
      3'b110:  f3_alu = 4'b0011;
      3'b100:  f3_alu = 4'b0100;
      3'b010:  f3_alu = 4'b0101;
      default: f3_alu_ok = 1'b0;
    endcase
    case (opcode)
      7'b0110011: begin
        if ((funct7 == 7'b0000000 && f3_alu_ok) || (funct7 == 7'b0100000 && funct3 == 3'b000)) begin
          d_rs1 = in_instr[19:15]; d_rs2 = in_instr[24:20]; d_rd = in_instr[11:7];
          d_alu = (funct7 == 7'b0100000) ? ALU_SUB : f3_alu;
          d_wen = 1'b1;
        end else d_ill = 1'b1;
      end
      7'b0010011: begin
        if (f3_alu_ok) begin
          d_rs1 = in_instr[19:15]; d_rd = in_instr[11:7];
          d_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
          d_alu = f3_alu; d_src = 1'b1; d_wen = 1'b1;
        end else d_ill = 1'b1;
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          d_rs1 = in_instr[19:15]; d_rd = in_instr[11:7];
          d_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
          d_src = 1'b1; d_wen = 1'b1; d_mren = 1'b1;
        end else d_ill = 1'b1;
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          d_rs1 = in_instr[19:15]; d_rs2 = in_instr[24:20];
          d_imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
          d_src = 1'b1; d_mwen = 1'b1;
        end else d_ill = 1'b1;
      end
      7'b1100011: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          d_rs1 = in_instr[19:15]; d_rs2 = in_instr[24:20];
          d_imm = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
          d_alu = ALU_SUB; d_br = 1'b1;
        end else d_ill = 1'b1;
      end
      7'b1101111: begin
        d_rd = in_instr[11:7];
        d_imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                 in_instr[20], in_instr[30:21], 1'b0};
        d_wen = 1'b1; d_jmp = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    // x0 is never a real destination
    if (d_rd == 5'd0) d_wen = 1'b0;
  end

  // Unused source indices decode to 0 and rd is nonzero here, so a plain compare suffices
  assign hazard = (HAZARD_EN == 1) && out_valid && mem_ren && (rd != 5'd0) &&
                  ((d_rs1 == rd) || (d_rs2 == rd));
  assign in_ready = !rst && (state == RUN) && !hazard && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign locked = (state == LOCKED);

  // Output bundle register, illegal counter and RUN/LOCKED state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      out_valid <= 1'b0; out_pc <= '0;
      rs1 <= '0; rs2 <= '0; rd <= '0; imm <= '0; alu_ctrl <= '0;
      alu_src <= 1'b0; reg_wen <= 1'b0; mem_ren <= 1'b0; mem_wen <= 1'b0;
      branch <= 1'b0; jump <= 1'b0; illegal <= 1'b0;
      illegal_count <= '0;
    end else if (accept) begin
      out_valid <= 1'b1; out_pc <= in_pc;
      rs1 <= d_rs1; rs2 <= d_rs2; rd <= d_rd; imm <= d_imm; alu_ctrl <= d_alu;
      alu_src <= d_src; reg_wen <= d_wen; mem_ren <= d_mren; mem_wen <= d_mwen;
      branch <= d_br; jump <= d_jmp; illegal <= d_ill;
      if (d_ill && illegal_count != LIMIT) begin
        illegal_count <= cnt_inc;
        if (cnt_inc == LIMIT) state <= LOCKED;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        src, wen, mren, mwen, br, jmp, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic in_ready, out_valid;
  logic [31:0] out_pc, imm;
  logic [4:0] rs1, rs2, rd;
  logic [3:0] alu_ctrl;
  logic alu_src, reg_wen, mem_ren, mem_wen, branch, jump, illegal, locked;
  logic [2:0] illegal_count;

  int checks = 0;
  int failures = 0;
  exp_t sb[$];

  decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_ctrl(alu_ctrl),
    .alu_src(alu_src), .reg_wen(reg_wen), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .branch(branch), .jump(jump), .illegal(illegal), .locked(locked),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  // flags = {src, wen, mren, mwen, br, jmp, ill}
  function automatic exp_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                              input logic [31:0] im, input logic [3:0] alu, input logic [6:0] flags);
    exp_t e;
    e.pc = '0; e.rs1 = r1; e.rs2 = r2; e.rd = d; e.imm = im; e.alu = alu;
    {e.src, e.wen, e.mren, e.mwen, e.br, e.jmp, e.ill} = flags;
    return e;
  endfunction

  // Scoreboard monitor: every completed output handshake must match the oldest expectation
  always @(negedge clk) begin
    exp_t act, e;
    #3;
    if (!rst && out_valid && out_ready) begin
      act = {out_pc, rs1, rs2, rd, imm, alu_ctrl, alu_src, reg_wen, mem_ren, mem_wen,
             branch, jump, illegal};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow: got bundle %h, required none", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL sb_bundle: got %h required %h", act, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e_in, output int waits);
    exp_t e;
    int n;
    e = e_in; e.pc = pc; n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout: instr %h not accepted in %0d cycles", instr, n);
    end else sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    waits = n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    #5;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d bundles outstanding, required 0", sb.size());
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; sb.delete();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] all_out;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h002081B3; #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    all_out = {out_pc} | {27'd0, rs1} | {27'd0, rs2} | {27'd0, rd} | imm | {28'd0, alu_ctrl} |
              {25'd0, alu_src, reg_wen, mem_ren, mem_wen, branch, jump, illegal};
    checks++;
    if ({out_valid, locked, illegal_count, all_out} !== 37'd0) begin
      failures++;
      $display("FAIL reset_state: got valid %b locked %b count %0d fields %h required all 0",
               out_valid, locked, illegal_count, all_out);
    end
    in_valid = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    int w1, w2;
    out_ready = 1'b1;
    send(32'h002081B3, 32'h100, mk(1, 2, 3, 0, 4'b0000, 7'b0100000), w1);
    send(32'h402081B3, 32'h104, mk(1, 2, 3, 0, 4'b0001, 7'b0100000), w2);
    checks++;
    if (w1 != 0 || w2 != 0) begin failures++; $display("FAIL b2b_ready: waits %0d/%0d required 0/0", w1, w2); end
    drain();
  endtask

  task automatic test_misc();
    int w;
    out_ready = 1'b1;
    send(32'hFE208CE3, 32'h200, mk(1, 2, 0, 32'hFFFFFFF8, 4'b0001, 7'b0000100), w);
    send(32'h0020A623, 32'h204, mk(1, 2, 0, 32'd12, 4'b0000, 7'b1001000), w);
    send(32'hFFDFF0EF, 32'h208, mk(0, 0, 1, 32'hFFFFFFFC, 4'b0000, 7'b0100010), w);
    send(32'h00208033, 32'h20C, mk(1, 2, 0, 0, 4'b0000, 7'b0000000), w);
    send(32'h0F017393, 32'h210, mk(2, 0, 7, 32'h000000F0, 4'b0010, 7'b1100000), w);
    send(32'h00109093, 32'h214, mk(0, 0, 0, 0, 4'b0000, 7'b0000001), w);
    send(32'h4020F033, 32'h218, mk(0, 0, 0, 0, 4'b0000, 7'b0000001), w);
    drain();
  endtask

  task automatic test_load_use();
    int w;
    out_ready = 1'b1;
    send(32'h0080A283, 32'h300, mk(1, 0, 5, 32'd8, 4'b0000, 7'b1110000), w);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h00228333; in_pc = 32'h304; #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++; $display("FAIL hazard_stall: in_ready %b out_valid %b required 0/1", in_ready, out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL hazard_bubble: out_valid %b in_ready %b required 0/1", out_valid, in_ready);
    end
    sb.push_back(exp_t'({32'h304, 5'd5, 5'd2, 5'd6, 32'd0, 4'b0000, 7'b0100000}));
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || rs1 !== 5'd5) begin
      failures++; $display("FAIL hazard_resume: out_valid %b rs1 %0d required 1/5", out_valid, rs1);
    end
    send(32'h0080A283, 32'h308, mk(1, 0, 5, 32'd8, 4'b0000, 7'b1110000), w);
    send(32'h00208333, 32'h30C, mk(1, 2, 6, 0, 4'b0000, 7'b0100000), w);
    checks++;
    if (w != 0) begin failures++; $display("FAIL no_hazard: waits %0d required 0", w); end
    drain();
  endtask

  task automatic test_backpressure();
    int w, bad;
    bad = 0;
    @(negedge clk); out_ready = 1'b0;
    send(32'hFFF08213, 32'h400, mk(1, 0, 4, 32'hFFFFFFFF, 4'b0000, 7'b1100000), w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin in_valid = 1'b1; in_instr = 32'h0F017393; in_pc = 32'h404; end
      #1;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || rd !== 5'd4 || imm !== 32'hFFFFFFFF ||
          out_pc !== 32'h400 || alu_src !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL hold_stable: %0d unstable cycles required 0", bad); end
    @(negedge clk); out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL release_ready: got %b required 1", in_ready); end
    sb.push_back(exp_t'({32'h404, 5'd2, 5'd0, 5'd7, 32'h000000F0, 4'b0010, 7'b1100000}));
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_midflight();
    int w;
    @(negedge clk); out_ready = 1'b0;
    send(32'h0080A283, 32'h500, mk(1, 0, 5, 32'd8, 4'b0000, 7'b1110000), w);
    @(negedge clk);
    rst = 1'b1; sb.delete();
    in_valid = 1'b1; in_instr = 32'h00228333; in_pc = 32'h504; #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checks++;
    if ({out_valid, mem_ren, rd, rs1, imm, out_pc} !== 76'd0) begin
      failures++; $display("FAIL midrst_clear: valid %b mren %b rd %0d imm %h pc %h required 0",
                           out_valid, mem_ren, rd, imm, out_pc);
    end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_no_stall: got %b required 1", in_ready); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(32'h00228333, 32'h508, mk(5, 2, 6, 0, 4'b0000, 7'b0100000), w);
    drain();
  endtask

  task automatic test_illegal_lockout();
    int w, hi;
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      send(32'hFFFFFFFF, 32'h600 + 4 * k, mk(0, 0, 0, 0, 4'b0000, 7'b0000001), w);
      checks++;
      if (illegal_count !== 3'(k) || locked !== (k == 4) || illegal !== 1'b1 || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL illegal_step%0d: count %0d locked %b illegal %b valid %b required %0d/%0d/1/1",
                 k, illegal_count, locked, illegal, out_valid, k, (k == 4));
      end
    end
    hi = 0;
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h002081B3;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (in_ready !== 1'b0) hi++;
    end
    in_valid = 1'b0;
    checks++;
    if (hi != 0 || out_valid !== 1'b0 || illegal_count !== 3'd4 || locked !== 1'b1) begin
      failures++;
      $display("FAIL locked_hold: ready cycles %0d valid %b count %0d locked %b required 0/0/4/1",
               hi, out_valid, illegal_count, locked);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (illegal_count !== 3'd0 || locked !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL unlock_reset: count %0d locked %b ready %b required 0/0/1", illegal_count, locked, in_ready);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_misc();
    test_load_use();
    test_backpressure();
    test_reset_midflight();
    test_illegal_lockout();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction decode stage for the RV32I subset core. It accepts a fetched instruction and PC over a valid/ready handshake and emits a complete decoded bundle through one output register: register indices, sign-extended immediate, ALU control and memory/branch/jump enables. It also stalls for load-use hazards and provides a security lockout that fences the pipeline after a configurable number of illegal instructions. It sits between fetch and register-file read/execute.

## Interface
- XLEN, 32: width of PC and immediate.
- ILLEGAL_LIMIT, 4: accepted illegal instructions that trigger lockout (≥1).
- CNT_W, $clog2(ILLEGAL_LIMIT+1): width of illegal_count.
- HAZARD_EN, 1: enables the load-use stall when set to 1.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch bundle valid.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- out_pc  out  XLEN  registered PC.
- rs1, rs2, rd  out  5 each  register indices.
- imm  out  XLEN  sign-extended immediate.
- alu_ctrl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt.
- alu_src  out  1  1 selects imm as ALU operand B.
- reg_wen, mem_ren, mem_wen, branch, jump  out  1 each  control enables.
- illegal  out  1  bundle is an illegal instruction.
- locked  out  1  lockout active.
- illegal_count  out  CNT_W  saturating illegal-instruction count.

## Operation
- Decode covers the following instructions:
  - R (0110011), funct3 000: add (funct7 0000000) or sub (funct7 0100000). Other R encodings: 111 and, 110 or, 100 xor, 010 slt, all with funct7 0000000.
  - I (0010011): addi 000, andi 111, ori 110, xori 100, slti 010. alu_src=1.
  - LOAD (0000011) funct3 010: mem_ren=1, alu add, alu_src=1, reg_wen.
  - STORE (0100011) funct3 010: mem_wen=1, alu add, alu_src=1, rd=0.
  - BRANCH (1100011) funct3 000/001: branch=1, alu sub, alu_src=0, rd=0.
  - JAL (1101111): jump=1, reg_wen, alu add.
- Any other opcode/funct combination is illegal. Its bundle has all enables 0, rs1/rs2/rd/imm/alu_ctrl 0, and illegal=1. It is still emitted downstream.
- Immediates, all sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R: imm=0.
- rs1/rs2 are driven only for formats that read them. All unused indices are 0.
- reg_wen is forced to 0 when rd==0.
- Load-use hazard (HAZARD_EN=1) is asserted when all of the following hold:
  - out_valid=1, mem_ren=1 and rd≠0 in the output register;
  - the incoming instruction reads that rd as rs1 (R/I/LOAD/STORE/BRANCH) or as rs2 (R/STORE/BRANCH).
- While the hazard is asserted, in_ready=0.
- State machine, 2 states:
  - RUN: in_ready = !hazard && (!out_valid || out_ready).
  - LOCKED: in_ready=0. The output register drains normally, and only rst exits LOCKED.
- Illegal counter: increments on each accepted illegal instruction and saturates at ILLEGAL_LIMIT. When the increment reaches ILLEGAL_LIMIT, the FSM enters LOCKED at the same edge.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is presented at out_* after edge N, with out_valid=1.
- out_* are held stable while out_valid && !out_ready.
- out_valid clears after an edge where out_ready=1 and nothing is accepted.
- Simultaneous accept and drain at the same edge gives back-to-back throughput, one instruction per cycle.
- A load-use hazard costs exactly one bubble when out_ready=1: the load drains, out_valid=0 for one cycle, then the dependent instruction is accepted.
- Reset values: out_valid 0, all out_* fields 0, illegal 0, locked 0, illegal_count 0, FSM RUN.
- in_ready is 0 while rst=1.
- Reset mid-operation discards any in-flight bundle, with no drain.
- An illegal instruction accepted in the same cycle the limit is reached is still emitted with illegal=1. locked=1 is visible in the same cycle as that bundle.

## Test plan
- add x3,x1,x2 (0x002081B3), then sub (0x402081B3) back-to-back with out_ready=1:
  - consecutive cycles show rs1=1, rs2=2, rd=3, reg_wen=1;
  - alu_ctrl is 0000 then 0001;
  - in_ready stays 1.
- beq x1,x2,-8 (0xFE208CE3): imm=0xFFFFFFF8, branch=1, alu_ctrl=0001, rd=0, reg_wen=0.
- lw x5,8(x1) (0x0080A283) then add x6,x5,x2 (0x00228333), out_ready=1:
  - in_ready=0 for one cycle and out_valid=0 for one cycle;
  - add is then emitted with rs1=5.
- out_ready=0 for 3 cycles with addi pending: out_* stable, in_ready=0. Releasing out_ready drains the bundle and accepts the next.
- 0xFFFFFFFF ×4 with ILLEGAL_LIMIT=4:
  - illegal=1 on each bundle, illegal_count 1..4;
  - locked=1 after the 4th;
  - in_ready stays 0 for 20 cycles;
  - rst then gives count 0, locked 0, in_ready 1.
- Assert rst while out_valid=1 holding a load: the next cycle shows out_valid 0, all outputs 0, and no stall.
